serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
- Receive side of the parallel-load/serial-shift link. Collects MSB-first serial frames on nrOfBits parallel lanes into a nrOfBits*nrOfStages parallel word.
- Presents each word to the consumer through a valid/ready holding register.
- Uses the same clock-enable (tick) and shift-enable qualification as the transmit shift register, so the two ends run in lockstep on one clock.

Parameters:
- nrOfBits, 1, number of serial lanes received in parallel.
- nrOfStages, 8, bits per lane per frame (>=2).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  clock enable; nothing advances except the consumer handshake when low.
- shiftEnable  input  1  a shift is accepted when shiftEnable & tick.
- shiftIn  input  nrOfBits  one serial bit per lane.
- frameStart  input  1  marks shiftIn as the first bit of a new frame.
- clearOverrun  input  1  clears the sticky overrun flag.
- q  output  nrOfBits*nrOfStages  received word; lane n occupies q[(n+1)*nrOfStages-1 : n*nrOfStages].
- qValid  output  1  q holds an unconsumed word.
- qReady  input  1  consumer accepts q when qValid & qReady at the clock edge.
- overrun  output  1  sticky: a completed frame was dropped.
- parityError  output  1  see Optional Feature; constant 0 when the feature is compiled out.
- bitCount  output  clog2(nrOfStages+1)  accepted shifts in the current partial frame.

Behaviour:
- Reset:
  - reset=1 at a rising edge clears the shift register, bitCount, the q holding register, qValid, overrun and parityError to 0.
  - reset takes priority over every other input.
  - Reset mid-frame discards the partial frame.
- Accepted shift (acc = shiftEnable & tick):
  - Each lane shifts left: stage0 <= shiftIn[n], stage k <= stage k-1.
  - The first received bit therefore ends in stage nrOfStages-1, matching the transmitter's shiftOut = stage nrOfStages-1.
  - bitCount increments.
- frameStart:
  - frameStart with acc: the bit is stored as the first bit and bitCount <= 1. The previous partial frame is discarded without flagging.
  - frameStart without acc: bitCount <= 0 and the partial frame is discarded.
  - If frameStart=1 and nrOfStages=1 would complete a frame, that is excluded by the parameter rule (nrOfStages>=2).
- Frame completion:
  - Triggered by an acc with bitCount == nrOfStages-1 and frameStart=0.
  - The full word is transferred to q at the same edge, with the just-received bit included.
  - bitCount <= 0.
  - Latency: q/qValid are visible the cycle after the last accepted shift edge.
- Handshake:
  - Consume = qValid & qReady, evaluated at every edge and independent of tick.
  - A consume clears qValid.
  - qReady with qValid=0 has no effect.
- Completion while qValid=1 and no consume:
  - The new word is dropped and q keeps the old word.
  - overrun <= 1.
  - The shift register still restarts at bitCount 0.
- Completion and consume in the same cycle: the new word is loaded, qValid stays 1 and no overrun is flagged.
- overrun:
  - Stays set until clearOverrun=1 or reset.
  - If clearOverrun and a new overrun occur in the same cycle, set wins.
- q is stable while qValid=1.
- The shift register contents are not visible on q until completion.

Optional Feature:
- Macro: SERIAL_FRAME_RX_PARITY_EN.
- With the macro defined:
  - Each frame carries one extra trailing bit per lane, so completion occurs at bitCount == nrOfStages.
  - The trailing bit is even parity over that lane's nrOfStages data bits.
  - The parity bit is not stored in q.
  - parityError is loaded with the OR of per-lane mismatches at each accepted completion, and is valid alongside qValid.
  - parityError is unchanged when the word is dropped on overrun.
  - bitCount width becomes clog2(nrOfStages+2).
- Without the macro: frames are exactly nrOfStages bits and parityError is tied 0.

Test Plan:
- Basic frame (nrOfBits=1, nrOfStages=8, tick=1, shiftEnable=1, frameStart on the first bit): shift 1,0,1,1,0,0,1,0 -> q=0xB2, qValid=1 one cycle after the 8th shift, bitCount=0; qReady pulse -> qValid=0.
- Two lanes: lane0 sends 0xA5 and lane1 sends 0x3C -> q=0x3CA5, qValid=1.
- Gaps: tick low on alternate cycles and shiftEnable low for 3 cycles mid-frame -> bitCount holds during gaps; the same 0xB2 result.
- Overrun: complete 0x11 without consuming, then complete 0x22 -> q=0x11, overrun=1. Completing 0x33 with qReady=1 on the completion edge -> q=0x33, qValid=1, overrun still 1. clearOverrun -> overrun=0.
- frameStart resync and reset: after 5 bits assert frameStart with a bit -> bitCount=1, and the next 7 bits form the word. Reset asserted mid-frame with qValid=1 -> all outputs 0 the next cycle.
- Parity (macro defined): 0xB2 followed by parity 0 -> parityError=0; followed by parity 1 -> parityError=1, q=0xB2.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: collects MSB-first frames on nrOfBits lanes into one parallel word.
// Latency: q/qValid are updated at the edge that accepts the last bit and are visible the next cycle.
// Backpressure: q is held until qValid & qReady. A frame that completes while q is still occupied is dropped and sets a sticky overrun flag.
// Optional feature SERIAL_FRAME_RX_PARITY_EN: adds one trailing even-parity bit per lane and drives parityError.
module serial_frame_receiver #(
    parameter int nrOfBits   = 1,
    parameter int nrOfStages = 8,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int FrameLen  = nrOfStages + 1,
`else
    localparam int FrameLen  = nrOfStages,
`endif
    localparam int CntW      = $clog2(FrameLen + 1),
    localparam int WordW     = nrOfBits * nrOfStages
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                shiftEnable,
    input  logic [nrOfBits-1:0] shiftIn,
    input  logic                frameStart,
    input  logic                clearOverrun,
    output logic [WordW-1:0]    q,
    output logic                qValid,
    input  logic                qReady,
    output logic                overrun,
    output logic                parityError,
    output logic [CntW-1:0]     bitCount
);

    logic [WordW-1:0] shift_q, shift_d;
    logic [WordW-1:0] hold_q, hold_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic [WordW-1:0] shifted;
    logic [WordW-1:0] done_word;
    logic             perr_now;
    logic             acc;
    logic             consume;
    logic             complete;

    assign acc      = shiftEnable & tick;
    assign consume  = valid_q & qReady;
    // Completion needs a non-start bit landing in the last frame position.
    assign complete = acc & ~frameStart & (cnt_q == CntW'(FrameLen - 1));

    // Per-lane left shift with the new serial bit entering stage 0.
    always_comb begin
        shifted = '0;
        for (int n = 0; n < nrOfBits; n++) begin
            shifted[n*nrOfStages +: nrOfStages] =
                {shift_q[n*nrOfStages +: nrOfStages-1], shiftIn[n]};
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // The last bit is the parity bit, so the data word is the register as it stands.
    always_comb begin
        done_word = shift_q;
        perr_now  = 1'b0;
        for (int n = 0; n < nrOfBits; n++) begin
            perr_now = perr_now | ((^shift_q[n*nrOfStages +: nrOfStages]) ^ shiftIn[n]);
        end
    end
`else
    // Without parity the final data bit is part of the word delivered at completion.
    always_comb begin
        done_word = shifted;
        perr_now  = 1'b0;
    end
`endif

    // Next-state for the shift register, bit counter and output holding register.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        valid_d = valid_q & ~consume;
        ovr_d   = ovr_q & ~clearOverrun;
        perr_d  = perr_q;

        if (acc) begin
            shift_d = shifted;
        end

        if (frameStart) begin
            // Resync: any partial frame is discarded silently.
            cnt_d = acc ? CntW'(1) : '0;
        end else if (complete) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (complete) begin
            if (!valid_q || consume) begin
                hold_d  = done_word;
                valid_d = 1'b1;
                perr_d  = perr_now;
            end else begin
                // Holding register still occupied: drop the new word, set wins over clear.
                ovr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign q           = hold_q;
    assign qValid      = valid_q;
    assign overrun     = ovr_q;
    assign parityError = perr_q;
    assign bitCount    = cnt_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver with two lanes of eight stages.
// Directed frames from the test plan followed by a randomized run against a word-level model.
// Every output is compared after each clock edge.
module tb_serial_frame_receiver;

    localparam int LANES  = 2;
    localparam int STAGES = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam int FL = STAGES + 1;
`else
    localparam int FL = STAGES;
`endif
    localparam int CW = $clog2(FL + 1);

    logic               clock = 1'b0;
    logic               reset, tick, shiftEnable, frameStart, clearOverrun, qReady;
    logic [LANES-1:0]   shiftIn;
    logic [15:0]        q;
    logic               qValid, overrun, parityError;
    logic [CW-1:0]      bitCount;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: words accumulated arithmetically per lane.
    int          m_word [LANES];
    int          m_cnt;
    logic [15:0] m_q;
    logic        m_valid, m_ovr, m_perr;

    serial_frame_receiver #(.nrOfBits(LANES), .nrOfStages(STAGES)) dut (
        .clock(clock), .reset(reset), .tick(tick), .shiftEnable(shiftEnable),
        .shiftIn(shiftIn), .frameStart(frameStart), .clearOverrun(clearOverrun),
        .q(q), .qValid(qValid), .qReady(qReady), .overrun(overrun),
        .parityError(parityError), .bitCount(bitCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, tk, se, fs, clr, rdy, input logic [LANES-1:0] si);
        int  d [LANES];
        bit  a, cons, cmpl, drop, pe, nv;
        if (rst) begin
            foreach (m_word[n]) m_word[n] = 0;
            m_cnt = 0; m_q = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        a    = se && tk;
        cons = m_valid && rdy;
        cmpl = a && !fs && (m_cnt == FL - 1);
        pe   = 0;
        for (int n = 0; n < LANES; n++) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            d[n] = m_word[n];
            if (($countones(d[n]) % 2) != int'(si[n])) pe = 1;
`else
            d[n] = (m_word[n] * 2 + int'(si[n])) % 256;
`endif
        end
        if (fs) begin
            m_cnt = a ? 1 : 0;
            for (int n = 0; n < LANES; n++) m_word[n] = a ? int'(si[n]) : 0;
        end else if (a) begin
            if (cmpl) begin
                m_cnt = 0;
                for (int n = 0; n < LANES; n++) m_word[n] = 0;
            end else begin
                m_cnt++;
                for (int n = 0; n < LANES; n++) m_word[n] = (m_word[n] * 2 + int'(si[n])) % 256;
            end
        end
        nv   = m_valid && !cons;
        drop = 0;
        if (cmpl) begin
            if (!m_valid || cons) begin
                m_q    = 16'(d[1] * 256 + d[0]);
                nv     = 1;
                m_perr = pe;
            end else begin
                drop = 1;
            end
        end
        m_valid = nv;
        if (clr)  m_ovr = 0;
        if (drop) m_ovr = 1;
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic step(input logic rst, tk, se, fs, clr, rdy, input logic [LANES-1:0] si);
        reset = rst; tick = tk; shiftEnable = se; frameStart = fs;
        clearOverrun = clr; qReady = rdy; shiftIn = si;
        @(posedge clock);
        model_update(rst, tk, se, fs, clr, rdy, si);
        #1;
        chk("q",           32'(q),           32'(m_q));
        chk("qValid",      32'(qValid),      32'(m_valid));
        chk("overrun",     32'(overrun),     32'(m_ovr));
        chk("bitCount",    32'(bitCount),    32'(m_cnt));
        chk("parityError", 32'(parityError), 32'(m_perr));
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(0, 1, 0, 0, clr, rdy, 2'b00);
    endtask

    // Send a full frame MSB first, frameStart on the first bit; qReady only on the last bit.
    task automatic send_frame(input logic [7:0] w0, w1, input logic rdy_last, input logic flip_par);
        for (int b = 7; b >= 0; b--) begin
            logic last;
            last = (b == 0) && (FL == STAGES);
            step(0, 1, 1, (b == 7), 0, last ? rdy_last : 1'b0, {w1[b], w0[b]});
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        step(0, 1, 1, 0, 0, rdy_last, {(^w1) ^ flip_par, (^w0) ^ flip_par});
`else
        if (flip_par) chk("flip_par_unused", 32'(flip_par), 32'(0));
`endif
    endtask

    initial begin
        logic [7:0] w;
        reset = 1; tick = 0; shiftEnable = 0; frameStart = 0;
        clearOverrun = 0; qReady = 0; shiftIn = '0;
        foreach (m_word[n]) m_word[n] = 0;
        m_cnt = 0; m_q = '0; m_valid = 0; m_ovr = 0; m_perr = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 2'b00);
        chk("rst_q", 32'(q), 0);
        chk("rst_qValid", 32'(qValid), 0);
        chk("rst_bitCount", 32'(bitCount), 0);

        // Basic frame 0xB2 on lane 0
        send_frame(8'hB2, 8'h00, 0, 0);
        chk("basic_q", 32'(q), 32'h00B2);
        chk("basic_valid", 32'(qValid), 1);
        chk("basic_cnt", 32'(bitCount), 0);
        idle(1, 0);
        chk("basic_consumed", 32'(qValid), 0);

        // Two lanes
        send_frame(8'hA5, 8'h3C, 0, 0);
        chk("lanes_q", 32'(q), 32'h3CA5);
        idle(1, 0);

        // Gaps: tick low on alternate cycles, shiftEnable low for 3 cycles mid-frame
        w = 8'hB2;
        for (int b = 7; b >= 0; b--) begin
            step(0, 0, 1, (b == 7), 0, 0, {1'b0, w[b]});
            chk("gap_tick_hold", 32'(bitCount), 32'(7 - b));
            step(0, 1, 1, (b == 7), 0, 0, {1'b0, w[b]});
            if (b == 4) begin
                for (int g = 0; g < 3; g++) begin
                    step(0, 1, 0, 0, 0, 0, 2'b11);
                    chk("gap_se_hold", 32'(bitCount), 4);
                end
            end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        step(0, 1, 1, 0, 0, 0, {1'b0, ^w});
`endif
        chk("gap_q", 32'(q), 32'h00B2);
        idle(1, 0);

        // Overrun sequence
        send_frame(8'h11, 8'h00, 0, 0);
        send_frame(8'h22, 8'h00, 0, 0);
        chk("ovr_q_kept", 32'(q), 32'h0011);
        chk("ovr_flag", 32'(overrun), 1);
        send_frame(8'h33, 8'h00, 1, 0);
        chk("ovr_swap_q", 32'(q), 32'h0033);
        chk("ovr_swap_valid", 32'(qValid), 1);
        chk("ovr_sticky", 32'(overrun), 1);
        idle(1, 1);
        chk("ovr_cleared", 32'(overrun), 0);

        // frameStart resync after 5 bits
        for (int b = 0; b < 5; b++) step(0, 1, 1, (b == 0), 0, 0, 2'b01);
        w = 8'h5A;
        step(0, 1, 1, 1, 0, 0, {1'b0, w[7]});
        chk("resync_cnt", 32'(bitCount), 1);
        for (int b = 6; b >= 0; b--) step(0, 1, 1, 0, 0, 0, {1'b0, w[b]});
`ifdef SERIAL_FRAME_RX_PARITY_EN
        step(0, 1, 1, 0, 0, 0, {1'b0, ^w});
`endif
        chk("resync_q", 32'(q), 32'h005A);

        // Reset mid-frame with qValid=1
        for (int b = 0; b < 3; b++) step(0, 1, 1, (b == 0), 0, 0, 2'b11);
        step(1, 1, 1, 0, 0, 0, 2'b11);
        chk("midrst_q", 32'(q), 0);
        chk("midrst_valid", 32'(qValid), 0);
        chk("midrst_cnt", 32'(bitCount), 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(8'hB2, 8'h00, 0, 0);
        chk("par_ok", 32'(parityError), 0);
        idle(1, 0);
        send_frame(8'hB2, 8'h00, 0, 1);
        chk("par_bad", 32'(parityError), 1);
        chk("par_q", 32'(q), 32'h00B2);
        idle(1, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) == 0),
                 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
